// File: rtl/mux8_arb_pkg.sv
// Shared constants and types for the 8-requester round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input sel_t idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Circular priority picker: first set bit of mask searched from ptr upward,
// wrapping 7 -> 0.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  sel_t             ptr,
  output logic             valid,
  output sel_t             idx
);

  sel_t cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    // Walk offsets from farthest to nearest; the nearest hit is written last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = sel_t'(ptr + i[SEL_W-1:0]);
      if (mask[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux, with an
// optional per-tenure hold limit after which priority rotates.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             expired
);

  localparam bit              HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_t            state;
  sel_t              ptr;
  logic [HOLD_W-1:0] count;

  logic [N_REQ-1:0]  pick_mask;
  sel_t              pick_ptr;
  sel_t              next_ptr;
  logic              pick_valid;
  sel_t              pick_idx;

  // During a tenure the owner is masked out and the search starts just past
  // it; on release the owner's req bit is already low so the mask is the same.
  assign next_ptr  = sel_t'(sel + 1'b1);
  assign pick_mask = (state == GRANT) ? (req & ~gnt) : req;
  assign pick_ptr  = (state == GRANT) ? next_ptr : ptr;

  rr_pick8 u_pick (
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
      ptr     <= '0;
      count   <= '0;
    end else begin
      expired <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && pick_valid) begin
            state <= GRANT;
            gnt   <= onehot(pick_idx);
            sel   <= pick_idx;
            busy  <= 1'b1;
            count <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            ptr <= next_ptr;
            if (en && pick_valid) begin
              gnt   <= onehot(pick_idx);
              sel   <= pick_idx;
              count <= HOLD_W'(1);
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              count <= '0;
            end
          end else if (HOLD_EN && (count == HOLD_LIM)) begin
            // Without a different eligible requester the owner is re-granted
            // in place, only its hold count restarts.
            expired <= 1'b1;
            ptr     <= next_ptr;
            count   <= HOLD_W'(1);
            if (en && pick_valid) begin
              gnt <= onehot(pick_idx);
              sel <= pick_idx;
            end
          end else if (count != {HOLD_W{1'b1}}) begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter against a behavioural arbitration
// model; directed scenarios followed by randomized traffic.
module tb_mux8_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       expired;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .expired (expired)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: who owns the mux, where priority starts, tenure length.
  bit m_busy;
  bit m_exp;
  int m_sel;
  int m_ptr;
  int m_cnt;

  function automatic int pick(input logic [7:0] mask, input int start);
    for (int k = 0; k < 8; k++) begin
      if (mask[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_gnt();
    return m_busy ? (8'h01 << m_sel) : 8'h00;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_exp = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic e);
    logic [7:0] others;
    m_exp = 0;
    if (!m_busy) begin
      if (e && r != 8'h00) begin
        m_sel = pick(r, m_ptr); m_busy = 1; m_cnt = 1;
      end
    end else if (!r[m_sel]) begin
      m_ptr = (m_sel + 1) % 8;
      if (e && r != 8'h00) begin
        m_sel = pick(r, m_ptr); m_cnt = 1;
      end else begin
        m_busy = 0; m_cnt = 0;
      end
    end else if (MAXH != 0 && m_cnt == MAXH) begin
      m_exp  = 1;
      m_ptr  = (m_sel + 1) % 8;
      m_cnt  = 1;
      others = r & ~(8'h01 << m_sel);
      if (e && others != 8'h00) m_sel = pick(others, m_ptr);
    end else begin
      m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
    end
  endtask

  // Apply inputs for one cycle, advance the model on the edge, settle after it.
  task automatic drive(input logic [7:0] r, input logic e);
    req = r;
    en  = e;
    @(posedge clk);
    model_edge(r, e);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({gnt, sel, busy, expired} !== 13'h0)
      $display("FAIL reset: gnt=%h sel=%0d busy=%b exp=%b, want all zero", gnt, sel, busy, expired);
    else passes++;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    logic [7:0] rs[5] = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      drive(rs[i], 1'b1);
      checks++;
      if ({gnt, sel, busy, expired} !== {m_gnt(), 3'(m_sel), m_busy, m_exp})
        $display("FAIL single[%0d]: gnt=%h sel=%0d busy=%b exp=%b, want gnt=%h sel=%0d busy=%b exp=%b",
                 i, gnt, sel, busy, expired, m_gnt(), m_sel, m_busy, m_exp);
      else passes++;
    end
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b0)
      $display("FAIL single_idle: gnt=%h busy=%b, want gnt=00 busy=0", gnt, busy);
    else passes++;
  endtask

  task automatic test_rotation();
    logic [7:0] r = 8'b1000_0011;
    int order[$];
    for (int i = 0; i < 7; i++) begin
      drive(r, 1'b1);
      checks++;
      if ({gnt, sel, busy, expired} !== {m_gnt(), 3'(m_sel), m_busy, m_exp})
        $display("FAIL rotation[%0d]: gnt=%h sel=%0d busy=%b exp=%b, want gnt=%h sel=%0d busy=%b exp=%b",
                 i, gnt, sel, busy, expired, m_gnt(), m_sel, m_busy, m_exp);
      else passes++;
      if (busy === 1'b1 && m_cnt == 1) order.push_back(int'(sel));
      if (m_busy && m_cnt == 2) r = r & ~m_gnt();
    end
    checks++;
    if (order.size() != 3 || order[0] != 7 || order[1] != 0 || order[2] != 1)
      $display("FAIL rotation_order: got %p, want '{7, 0, 1}", order);
    else passes++;
  endtask

  task automatic test_expiry();
    int pulses = 0;
    bit held = 1;
    for (int i = 0; i < 10; i++) begin
      drive(8'h20, 1'b1);
      checks++;
      if ({gnt, sel, busy, expired} !== {m_gnt(), 3'(m_sel), m_busy, m_exp})
        $display("FAIL expiry[%0d]: gnt=%h sel=%0d busy=%b exp=%b, want gnt=%h sel=%0d busy=%b exp=%b",
                 i, gnt, sel, busy, expired, m_gnt(), m_sel, m_busy, m_exp);
      else passes++;
      if (expired === 1'b1) pulses++;
      if (gnt !== 8'h20) held = 0;
    end
    checks++;
    if (pulses != 2 || !held)
      $display("FAIL expiry_pulses: pulses=%0d held=%b, want pulses=2 held=1", pulses, held);
    else passes++;
    drive(8'h00, 1'b1);
  endtask

  task automatic test_expiry_handoff();
    drive(8'h20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(8'h60, 1'b1);
      checks++;
      if ({gnt, sel, busy, expired} !== {m_gnt(), 3'(m_sel), m_busy, m_exp})
        $display("FAIL handoff[%0d]: gnt=%h sel=%0d busy=%b exp=%b, want gnt=%h sel=%0d busy=%b exp=%b",
                 i, gnt, sel, busy, expired, m_gnt(), m_sel, m_busy, m_exp);
      else passes++;
    end
    checks++;
    if (gnt !== 8'h40 || sel !== 3'd6)
      $display("FAIL handoff_owner: gnt=%h sel=%0d, want gnt=40 sel=6", gnt, sel);
    else passes++;
    drive(8'h00, 1'b1);
  endtask

  task automatic test_en_block();
    bit kept = 1;
    drive(8'h08, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(8'h0A, 1'b0);
      checks++;
      if ({gnt, sel, busy, expired} !== {m_gnt(), 3'(m_sel), m_busy, m_exp})
        $display("FAIL en_hold[%0d]: gnt=%h sel=%0d busy=%b exp=%b, want gnt=%h sel=%0d busy=%b exp=%b",
                 i, gnt, sel, busy, expired, m_gnt(), m_sel, m_busy, m_exp);
      else passes++;
      if (gnt !== 8'h08) kept = 0;
    end
    checks++;
    if (!kept) $display("FAIL en_owner_kept: kept=0, want 1");
    else passes++;
    for (int i = 0; i < 4; i++) drive(8'h02, 1'b0);
    checks++;
    if (busy !== 1'b0 || gnt !== 8'h00)
      $display("FAIL en_blocked: gnt=%h busy=%b, want gnt=00 busy=0", gnt, busy);
    else passes++;
    drive(8'h02, 1'b1);
    checks++;
    if (gnt !== 8'h02 || sel !== 3'd1 || busy !== 1'b1)
      $display("FAIL en_resume: gnt=%h sel=%0d busy=%b, want gnt=02 sel=1 busy=1", gnt, sel, busy);
    else passes++;
    drive(8'h00, 1'b1);
  endtask

  task automatic test_async_reset();
    drive(8'h10, 1'b1);
    drive(8'h10, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, sel, busy, expired} !== 13'h0)
      $display("FAIL async_reset: gnt=%h sel=%0d busy=%b exp=%b, want all zero", gnt, sel, busy, expired);
    else passes++;
    model_reset();
    #2 rst_n = 1'b1;
    drive(8'hFF, 1'b1);
    checks++;
    if (gnt !== 8'h01 || sel !== 3'd0 || gnt !== m_gnt())
      $display("FAIL post_reset_grant: gnt=%h sel=%0d, want gnt=01 sel=0", gnt, sel);
    else passes++;
    drive(8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] r = 8'h00;
    logic       e = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = 8'($urandom) & 8'($urandom);
      e = ($urandom_range(0, 7) != 0);
      drive(r, e);
      checks++;
      if ({gnt, sel, busy, expired} !== {m_gnt(), 3'(m_sel), m_busy, m_exp})
        $display("FAIL random[%0d] req=%h en=%b: gnt=%h sel=%0d busy=%b exp=%b, want gnt=%h sel=%0d busy=%b exp=%b",
                 i, r, e, gnt, sel, busy, expired, m_gnt(), m_sel, m_busy, m_exp);
      else passes++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_expiry();
    test_expiry_handoff();
    test_en_block();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
